// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit for the MEM stage, initiator side of a byte-addressed
// data memory with a combinational 32-bit little-endian read and a 4-byte write
// on posedge clk. RV32I LB/LH/LW/LBU/LHU/SB/SH/SW become word-only memory
// transactions: sub-word stores use read-modify-write, loads are sign/zero
// extended. One transaction in flight, valid/ready on both pipeline sides.
//
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake (ready iff IDLE)
//   req_store, req_funct3      operation select (RV32I funct3 encoding)
//   req_addr, req_wdata        byte address, store data
//   rsp_valid/rsp_ready        response handshake, response held until accepted
//   rsp_rdata, rsp_err         extended load data (0 for stores), error flag
//   mem_we, mem_addr           memory write enable, word-aligned byte address
//   mem_wdata, mem_rdata       memory write data, combinational read data
//
// Build option: DMEM_LSU_ALIGN_CHECK_EN -- when defined, misaligned accesses
// complete with rsp_err=1 and no memory access; when undefined, the address
// is forced aligned and the access proceeds.
module dmem_lsu #(
  parameter int AW = 20
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_store,
  input  logic [2:0]    req_funct3,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_e;

  state_e        state_q, state_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    off_q, off_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  // Doubles as the RMW merge register: it is loaded with the merged word in
  // RMW_RD (or the store data for SW) and presented unchanged during WRITE.
  logic [31:0]   mem_wdata_q, mem_wdata_d;

  logic          illegal;
  logic          bad;
  logic [1:0]    req_off;
  logic [31:0]   shifted;
  logic [31:0]   load_ext;
  logic [31:0]   lane_mask;
  logic [31:0]   merged;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  // Decoded straight from state so reset drops it asynchronously.
  assign mem_we    = (state_q == WRITE);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  always_comb begin
    if (req_store) illegal = (req_funct3 >= 3'b011);
    else           illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
`ifdef DMEM_LSU_ALIGN_CHECK_EN
    req_off = req_addr[1:0];
    bad     = illegal
            || ((req_funct3[1:0] == 2'b01) && req_addr[0])
            || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    bad = illegal;
    case (req_funct3[1:0])
      2'b01:   req_off = {req_addr[1], 1'b0};
      2'b10:   req_off = 2'b00;
      default: req_off = req_addr[1:0];
    endcase
`endif
  end

  always_comb begin
    shifted = mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {24'h000000, shifted[7:0]};
      3'b101:  load_ext = {16'h0000, shifted[15:0]};
      default: load_ext = mem_rdata;
    endcase
    lane_mask = (f3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << {off_q, 3'b000};
    merged    = (mem_rdata & ~lane_mask) | ((wdata_q << {off_q, 3'b000}) & lane_mask);
  end

  always_comb begin
    state_d     = state_q;
    f3_d        = f3_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          f3_d    = req_funct3;
          off_d   = req_off;
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = bad;
          if (bad) begin
            state_d = RESP;
          end else begin
            mem_addr_d = {req_addr[AW-1:2], 2'b00};
            if (!req_store) begin
              state_d = LOAD;
            end else if (req_funct3[1:0] == 2'b10) begin
              state_d     = WRITE;
              mem_wdata_d = req_wdata;
            end else begin
              state_d = RMW_RD;
            end
          end
        end
      end
      LOAD: begin
        rdata_d = load_ext;
        state_d = RESP;
      end
      RMW_RD: begin
        mem_wdata_d = merged;
        state_d     = WRITE;
      end
      WRITE: state_d = RESP;
      RESP:  if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      f3_q        <= '0;
      off_q       <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu with a byte-array memory model.
module tb_dmem_lsu;
  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_store = 1'b0;
  logic [2:0]    req_funct3 = 3'b000;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  dmem_lsu #(.AW(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [7:0] m [0:511];
  int unsigned maddr;
  assign maddr = 32'(mem_addr[7:0]);
  assign mem_rdata = {m[maddr+3], m[maddr+2], m[maddr+1], m[maddr]};

  int we_cnt = 0;
  logic [AW-1:0] we_addr = '0;
  logic [31:0] we_data = '0;
  always @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) m[maddr + b] = mem_wdata[8*b +: 8];
      we_cnt = we_cnt + 1;
      we_addr = mem_addr;
      we_data = mem_wdata;
    end
  end

  function automatic logic [31:0] word_at(input int a);
    return {m[a+3], m[a+2], m[a+1], m[a]};
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;
  exp_t sb[$];
  bit seen = 1'b0;

  // Monitor: latency checked when a response first appears, data/err on handshake.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && rsp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        if (!seen) begin
          chk("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
          seen = 1'b1;
        end
        if (rsp_ready) begin
          e = sb.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          seen = 1'b0;
        end
      end
    end
  end

  task automatic issue(input logic st, input logic [2:0] f3, input logic [AW-1:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rd,
                       input logic exp_err, input int lat);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", 32'(req_ready), 32'd1);
      return;
    end
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    e.rdata = exp_rd; e.err = exp_err; e.lat = lat; e.acc = cyc;
    sb.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int snap;
  initial begin
    for (int i = 0; i < 512; i++) m[i] = 8'h00;
    {m[15], m[14], m[13], m[12]} = 32'hF9FF_FFF7;
    {m[35], m[34], m[33], m[32]} = 32'h0000_0004;
    {m[7],  m[6],  m[5],  m[4]}  = 32'hCAFE_F00D;
    {m[51], m[50], m[49], m[48]} = 32'h1122_3344;

    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Loads with sign/zero extension.
    issue(1'b0, 3'b000, 20'h0C, 32'h0, 32'hFFFF_FFF7, 1'b0, 2);
    issue(1'b0, 3'b100, 20'h0F, 32'h0, 32'h0000_00F9, 1'b0, 2);
    issue(1'b0, 3'b001, 20'h0E, 32'h0, 32'hFFFF_F9FF, 1'b0, 2);
    drain();

    // Byte store via read-modify-write.
    snap = we_cnt;
    issue(1'b1, 3'b000, 20'h21, 32'h0000_00AB, 32'h0, 1'b0, 3);
    drain();
    chk("sb_we_pulses", 32'(we_cnt - snap), 32'd1);
    chk("sb_we_addr", 32'(we_addr), 32'h20);
    chk("sb_we_data", we_data, 32'h0000_AB04);
    issue(1'b0, 3'b010, 20'h20, 32'h0, 32'h0000_AB04, 1'b0, 2);

    // Word store then halfword merge.
    issue(1'b1, 3'b010, 20'h24, 32'h1234_5678, 32'h0, 1'b0, 2);
    issue(1'b1, 3'b001, 20'h26, 32'h0000_BEEF, 32'h0, 1'b0, 3);
    drain();
    chk("sh_word24", word_at(36), 32'hBEEF_5678);
    issue(1'b0, 3'b101, 20'h26, 32'h0, 32'h0000_BEEF, 1'b0, 2);
    drain();

    // Misaligned word load.
    snap = we_cnt;
`ifdef DMEM_LSU_ALIGN_CHECK_EN
    issue(1'b0, 3'b010, 20'h05, 32'h0, 32'h0, 1'b1, 1);
    issue(1'b1, 3'b001, 20'h27, 32'h0000_5555, 32'h0, 1'b1, 1);
`else
    issue(1'b0, 3'b010, 20'h05, 32'h0, 32'hCAFE_F00D, 1'b0, 2);
`endif
    drain();
    chk("misalign_no_we", 32'(we_cnt - snap), 32'd0);

    // Illegal funct3.
    snap = we_cnt;
    issue(1'b0, 3'b011, 20'h0C, 32'h0, 32'h0, 1'b1, 1);
    issue(1'b1, 3'b011, 20'h0C, 32'hFFFF_FFFF, 32'h0, 1'b1, 1);
    issue(1'b1, 3'b100, 20'h0C, 32'hFFFF_FFFF, 32'h0, 1'b1, 1);
    drain();
    chk("illegal_no_we", 32'(we_cnt - snap), 32'd0);
    chk("illegal_word0c", word_at(12), 32'hF9FF_FFF7);

    // Response backpressure.
    rsp_ready = 1'b0;
    issue(1'b0, 3'b010, 20'h0C, 32'h0, 32'hF9FF_FFF7, 1'b0, 2);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_rdata", rsp_rdata, 32'hF9FF_FFF7);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_rsp", 32'(req_ready), 32'd1);
    issue(1'b0, 3'b100, 20'h0C, 32'h0, 32'h0000_00F7, 1'b0, 2);
    drain();

    // Reset during WRITE of a byte RMW to word 0x30.
    snap = we_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000;
    req_addr = 20'h31; req_wdata = 32'h0000_0055;
    @(posedge clk);
    #1 req_valid = 1'b0;
    begin
      int n = 0;
      @(negedge clk);
      while (!mem_we && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    chk("reach_write", 32'(mem_we), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_mem_we", 32'(mem_we), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_we", 32'(we_cnt - snap), 32'd0);
    chk("abort_word30", word_at(48), 32'h1122_3344);
    chk("abort_no_rsp", 32'(rsp_valid), 32'd0);

    issue(1'b0, 3'b010, 20'h30, 32'h0, 32'h1122_3344, 1'b0, 2);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store unit in the MEM stage; the initiator side of the byte-addressed data memory.
- The data memory has a combinational 32-bit little-endian read at any byte address. On a write, it writes 4 bytes (addr..addr+3) on posedge clk.
- This block turns RV32I LB/LH/LW/LBU/LHU/SB/SH/SW into word-only memory transactions:
  - sub-word stores use read-modify-write on the aligned word;
  - loads are sign- or zero-extended.
- Valid/ready handshake to the pipeline; one transaction in flight.

Parameters:
- AW, 20, byte-address width of the data memory.

Ports:
- clk  in  1  clock; all state updates on posedge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  pipeline request valid
- req_ready  out  1  LSU can accept a request (high iff state IDLE)
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- req_addr  in  AW  byte address
- req_wdata  in  32  store data (low bits used for B/H)
- rsp_valid  out  1  response valid, held until accepted
- rsp_ready  in  1  pipeline accepts response
- rsp_rdata  out  32  extended load data; 0 for stores
- rsp_err  out  1  misaligned or illegal access; no memory side effect
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory byte address, always word-aligned (low 2 bits 0)
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory combinational read data

Behaviour:
- Reset (async, reset_n=0): state IDLE. rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_we=0, mem_addr=0, mem_wdata=0; req_ready=1. All internal latches cleared.
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- Request latching: in IDLE, req_valid=1 latches op, funct3, addr, wdata. base = addr with bits[1:0] cleared; off = addr[1:0].
- IDLE transitions:
  - illegal or misaligned request: RESP with err=1;
  - load: LOAD;
  - SW: WRITE;
  - SB/SH: RMW_RD.
- Illegal: load funct3 011/110/111; store funct3 >= 011.
- Misaligned: H/HU/SH with off[0]=1; W/SW with off != 0.
- LOAD: mem_addr=base. Capture mem_rdata, then extract:
  - byte = word[8*off +: 8];
  - halfword = word[8*off +: 16];
  - B/H sign-extend; BU/HU zero-extend.
  - Result goes to rsp_rdata; next state RESP.
- RMW_RD: mem_addr=base. Capture mem_rdata into the merge register; next state WRITE.
- WRITE: mem_we=1, mem_addr=base.
  - mem_wdata = wdata for SW;
  - mem_wdata = merge register with byte/halfword lane(s) at off replaced by wdata[7:0]/[15:0] for SB/SH.
  - Next state RESP.
- RESP: rsp_valid=1, rsp_rdata/rsp_err stable. On rsp_ready=1, go to IDLE; otherwise hold.
- Outside LOAD/RMW_RD/WRITE, mem_we=0 and mem_addr holds its last value.
- Latency from accept edge to rsp_valid:
  - error: 1 cycle;
  - load: 2 cycles;
  - SW: 2 cycles;
  - SB/SH: 3 cycles.
- Back-to-back: a new request is accepted in the cycle after the RESP handshake (req_ready low during RESP). Max throughput is 1 load per 3 cycles.
- Stores return rsp_rdata=0, rsp_err=0.
- Reset mid-operation: state returns to IDLE immediately and mem_we drops asynchronously. A RMW interrupted before the WRITE edge leaves memory unmodified. No response is produced for the aborted request.
- Inputs req_* are ignored outside IDLE.

Optional Feature:
- Macro DMEM_LSU_ALIGN_CHECK_EN.
- Defined: misaligned accesses report rsp_err=1 with no memory access, as above.
- Undefined:
  - misalignment is not detected;
  - the address is forced aligned (H/HU/SH clear addr[0]; W/SW clear addr[1:0]);
  - the access proceeds normally;
  - rsp_err is asserted only for illegal funct3.

Test Plan:
- Preload word@0x0C=0xF9FFFFF7. LB 0x0C -> rsp_rdata=0xFFFFFFF7. LBU 0x0F -> 0x000000F9. LH 0x0E -> 0xFFFFF9FF. rsp_valid 2 cycles after accept each.
- Preload word@0x20=0x00000004. SB 0x21 wdata=0xAB -> exactly one mem_we pulse at mem_addr 0x20 with mem_wdata 0x0000AB04, rsp_valid 3 cycles after accept. LW 0x20 then -> 0x0000AB04.
- SW 0x24 wdata=0x12345678, then SH 0x26 wdata=0xBEEF -> word@0x24 = 0xBEEF5678. LHU 0x26 -> 0x0000BEEF.
- LW 0x05 (macro defined) -> rsp_err=1 after 1 cycle, mem_we never asserted. Same with macro undefined -> data of word@0x04, rsp_err=0.
- Hold rsp_ready=0 for 5 cycles after a load -> rsp_valid/rsp_rdata stable, req_ready=0; release -> IDLE next cycle and a new request is accepted.
- Pulse reset_n low while in WRITE before the clock edge -> mem_we drops immediately, target word unchanged, rsp_valid=0, req_ready=1.
